// File: rtl/gcn_pkg.sv
// Shared types and width helpers for the single-layer GCN inference engine.
package gcn_pkg;

    typedef enum logic [2:0] {IDLE, ADJ, FETCH, DRAIN, OUT, DONE} state_t;

    function automatic int node_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cls_w(int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic int prod_w(int bw, int elems);
        return 2 * bw + $clog2(elems);
    endfunction

    function automatic int acc_w(int pw, int n);
        return pw + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gcn_dot_row.sv
// Combinational unsigned dot product of two packed element rows.
module gcn_dot_row import gcn_pkg::*; #(
    parameter int ELEMS  = 96,
    parameter int BW     = 5,
    parameter int PROD_W = prod_w(BW, ELEMS)
) (
    input  logic [ELEMS*BW-1:0] a,
    input  logic [ELEMS*BW-1:0] b,
    output logic [PROD_W-1:0]   dot
);

    logic [ELEMS-1:0][2*BW-1:0] prod;
    logic [PROD_W-1:0]          acc;

    for (genvar i = 0; i < ELEMS; i++) begin : g_lane
        assign prod[i] = (2*BW)'(a[i*BW +: BW]) * (2*BW)'(b[i*BW +: BW]);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < ELEMS; i++) acc = acc + PROD_W'(prod[i]);
    end

    assign dot = acc;

endmodule

// File: rtl/gcn_layer_engine.sv
// Single-layer GCN: COO -> adjacency, X*W into a buffer, A*(XW) argmax per node.
// Optional macro GCN_SELF_LOOP_EN adds the identity to the adjacency (A+I).
module gcn_layer_engine import gcn_pkg::*; #(
    parameter int NUM_NODES   = 6,
    parameter int NUM_CLASSES = 3,
    parameter int NUM_EDGES   = 6,
    parameter int ELEMS       = 96,
    parameter int BW          = 5,
    localparam int NODE_W = node_w(NUM_NODES),
    localparam int CLS_W  = cls_w(NUM_CLASSES),
    localparam int PROD_W = prod_w(BW, ELEMS),
    localparam int ACC_W  = acc_w(PROD_W, NUM_NODES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_EDGES*NODE_W-1:0] coo_src,
    input  logic [NUM_EDGES*NODE_W-1:0] coo_dst,
    output logic                        input_re,
    output logic [NODE_W-1:0]           input_addr_fm,
    output logic [CLS_W-1:0]            input_addr_wm,
    input  logic [ELEMS*BW-1:0]         row_features,
    input  logic [ELEMS*BW-1:0]         row_weights,
    output logic                        output_we,
    output logic [NODE_W-1:0]           output_addr,
    output logic [CLS_W-1:0]            y,
    output logic                        busy,
    output logic                        done
);

    localparam logic [NODE_W:0]   NN     = (NODE_W+1)'(NUM_NODES);
    localparam logic [NODE_W-1:0] LAST_N = NODE_W'(NUM_NODES - 1);
    localparam logic [CLS_W-1:0]  LAST_C = CLS_W'(NUM_CLASSES - 1);

    state_t state;

    logic [NUM_EDGES-1:0][NODE_W-1:0]                 e_src, e_dst;
    logic [NUM_NODES-1:0][NUM_NODES-1:0]              adj, adj_nxt;
    logic [NUM_NODES-1:0][NUM_CLASSES-1:0][PROD_W-1:0] xw;

    logic              cap_vld;
    logic [NODE_W-1:0] cap_fm;
    logic [CLS_W-1:0]  cap_wm;
    logic [PROD_W-1:0] dot;

    logic [NODE_W-1:0]                   calc_node;
    logic [NUM_NODES-1:0]                adj_row;
    logic [PROD_W-1:0]                   xv;
    logic [NUM_CLASSES-1:0][ACC_W-1:0]   agg;
    logic [ACC_W-1:0]                    best_v;
    logic [CLS_W-1:0]                    best_c;

    gcn_dot_row #(.ELEMS(ELEMS), .BW(BW), .PROD_W(PROD_W)) u_dot (
        .a   (row_features),
        .b   (row_weights),
        .dot (dot)
    );

    // Symmetric adjacency from the latched edge list; out-of-range edges are dropped.
    always_comb begin
        adj_nxt = '0;
        for (int e = 0; e < NUM_EDGES; e++) begin
            if ({1'b0, e_src[e]} < NN && {1'b0, e_dst[e]} < NN) begin
                adj_nxt[e_src[e]][e_dst[e]] = 1'b1;
                adj_nxt[e_dst[e]][e_src[e]] = 1'b1;
            end
        end
`ifdef GCN_SELF_LOOP_EN
        for (int i = 0; i < NUM_NODES; i++) adj_nxt[i][i] = 1'b1;
`else
`endif
    end

    // Node 0 is evaluated during DRAIN, so the in-flight XW write is bypassed in.
    always_comb begin
        calc_node = (state == OUT) ? output_addr + 1'b1 : '0;
        adj_row   = ({1'b0, calc_node} < NN) ? adj[calc_node] : '0;
        agg       = '0;
        xv        = '0;
        for (int j = 0; j < NUM_NODES; j++) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                xv = xw[j][c];
                if (cap_vld && cap_fm == NODE_W'(j) && cap_wm == CLS_W'(c)) xv = dot;
                if (adj_row[j]) agg[c] = agg[c] + ACC_W'(xv);
            end
        end
        best_c = '0;
        best_v = agg[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (agg[c] > best_v) begin
                best_v = agg[c];
                best_c = CLS_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            e_src         <= '0;
            e_dst         <= '0;
            adj           <= '0;
            xw            <= '0;
            cap_vld       <= 1'b0;
            cap_fm        <= '0;
            cap_wm        <= '0;
            input_re      <= 1'b0;
            input_addr_fm <= '0;
            input_addr_wm <= '0;
            output_we     <= 1'b0;
            output_addr   <= '0;
            y             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            cap_vld <= input_re;
            cap_fm  <= input_addr_fm;
            cap_wm  <= input_addr_wm;
            if (cap_vld) xw[cap_fm][cap_wm] <= dot;

            case (state)
                IDLE: if (start) begin
                    state <= ADJ;
                    busy  <= 1'b1;
                    e_src <= coo_src;
                    e_dst <= coo_dst;
                end
                ADJ: begin
                    adj           <= adj_nxt;
                    state         <= FETCH;
                    input_re      <= 1'b1;
                    input_addr_fm <= '0;
                    input_addr_wm <= '0;
                end
                // Class-major walk: node index is the inner counter.
                FETCH: begin
                    if (input_addr_fm == LAST_N) begin
                        input_addr_fm <= '0;
                        if (input_addr_wm == LAST_C) begin
                            input_re <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            input_addr_wm <= input_addr_wm + 1'b1;
                        end
                    end else begin
                        input_addr_fm <= input_addr_fm + 1'b1;
                    end
                end
                DRAIN: begin
                    state       <= OUT;
                    output_we   <= 1'b1;
                    output_addr <= '0;
                    y           <= best_c;
                end
                OUT: begin
                    if (output_addr == LAST_N) begin
                        output_we   <= 1'b0;
                        output_addr <= '0;
                        y           <= '0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        output_addr <= output_addr + 1'b1;
                        y           <= best_c;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_layer_engine.sv
// Randomized bench for gcn_layer_engine against a graph-level reference model.
module tb_gcn_layer_engine;

    localparam int N  = 6;
    localparam int C  = 3;
    localparam int E  = 6;
    localparam int EL = 96;
    localparam int BW = 5;
    localparam int NW = 3;
    localparam int CW = 2;
    localparam int NC = N * C;
    localparam int D  = NC + N + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [E*NW-1:0] coo_src = '0;
    logic [E*NW-1:0] coo_dst = '0;
    logic [EL*BW-1:0] row_features = '0;
    logic [EL*BW-1:0] row_weights = '0;
    logic            input_re;
    logic [NW-1:0]   input_addr_fm;
    logic [CW-1:0]   input_addr_wm;
    logic            output_we;
    logic [NW-1:0]   output_addr;
    logic [CW-1:0]   y;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    gcn_layer_engine #(.NUM_NODES(N), .NUM_CLASSES(C), .NUM_EDGES(E), .ELEMS(EL), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .coo_src(coo_src), .coo_dst(coo_dst),
        .input_re(input_re), .input_addr_fm(input_addr_fm), .input_addr_wm(input_addr_wm),
        .row_features(row_features), .row_weights(row_weights), .output_we(output_we),
        .output_addr(output_addr), .y(y), .busy(busy), .done(done)
    );

    int     feat[N][EL];
    int     wgt[C][EL];
    int     exp_y[N];
    longint exp_xw[N][C];
    int     got_y[N];
    int     errors = 0, checks = 0;
    int     cyc = 0, e0 = 0;
    bit     active = 1'b0;
    int     we_cnt = 0, done_cnt = 0, first_we_rel = 0, done_rel = 0;
    bit     pend_re = 1'b0;
    int     pend_fm = 0, pend_wm = 0;

    task automatic check(string nm, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference: graph rules applied with plain arrays.
    function void compute_model();
        bit     a[N][N];
        longint agg[C];
        int     s, d, best;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a[i][j] = 1'b0;
        for (int e = 0; e < E; e++) begin
            s = int'(coo_src[e*NW +: NW]);
            d = int'(coo_dst[e*NW +: NW]);
            if (s < N && d < N) begin
                a[s][d] = 1'b1;
                a[d][s] = 1'b1;
            end
        end
`ifdef GCN_SELF_LOOP_EN
        for (int i = 0; i < N; i++) a[i][i] = 1'b1;
`endif
        for (int n = 0; n < N; n++)
            for (int c = 0; c < C; c++) begin
                exp_xw[n][c] = 0;
                for (int k = 0; k < EL; k++) exp_xw[n][c] += feat[n][k] * wgt[c][k];
            end
        for (int n = 0; n < N; n++) begin
            for (int c = 0; c < C; c++) begin
                agg[c] = 0;
                for (int j = 0; j < N; j++) if (a[n][j]) agg[c] += exp_xw[j][c];
            end
            best = 0;
            for (int c = 1; c < C; c++) if (agg[c] > agg[best]) best = c;
            exp_y[n] = best;
        end
    endfunction

    function logic [EL*BW-1:0] pack_f(int r);
        logic [EL*BW-1:0] v;
        for (int k = 0; k < EL; k++) v[k*BW +: BW] = BW'(feat[r][k]);
        return v;
    endfunction

    function logic [EL*BW-1:0] pack_w(int r);
        logic [EL*BW-1:0] v;
        for (int k = 0; k < EL; k++) v[k*BW +: BW] = BW'(wgt[r][k]);
        return v;
    endfunction

    function logic [EL*BW-1:0] rnd_row();
        logic [EL*BW-1:0] v;
        for (int k = 0; k < EL; k++) v[k*BW +: BW] = BW'($urandom_range(0, 31));
        return v;
    endfunction

    // Run tracker: which edge sampled start, and whether a pass is in flight.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) active = 1'b0;
        else if ((!active || cyc - e0 >= D + 1) && start) begin
            e0 = cyc;
            active = 1'b1;
            compute_model();
        end else if (active && cyc - e0 >= D + 1) active = 1'b0;
    end

    // External memory: read data valid the cycle after input_re.
    always @(negedge clk) begin
        pend_re = input_re;
        pend_fm = int'(input_addr_fm);
        pend_wm = int'(input_addr_wm);
    end

    always @(posedge clk) begin
        #1;
        if (pend_re && pend_fm < N && pend_wm < C) begin
            row_features = pack_f(pend_fm);
            row_weights  = pack_w(pend_wm);
        end else begin
            row_features = rnd_row();
            row_weights  = rnd_row();
        end
    end

    // Per-cycle compare against the model timeline.
    always @(negedge clk) begin
        int rel, node;
        bit e_re, e_we, e_busy, e_done;
        if (!rst_n) begin
            check("rst_re", input_re, 0);
            check("rst_we", output_we, 0);
            check("rst_y", y, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end else begin
            rel    = cyc - e0 + 1;
            e_busy = active && rel <= D;
            e_re   = active && rel >= 2 && rel <= NC + 1;
            e_we   = active && rel >= NC + 3 && rel <= NC + N + 2;
            e_done = active && rel == D;
            check("busy", busy, e_busy);
            check("input_re", input_re, e_re);
            check("output_we", output_we, e_we);
            check("done", done, e_done);
            if (e_re && input_re) begin
                check("addr_fm", input_addr_fm, (rel - 2) % N);
                check("addr_wm", input_addr_wm, (rel - 2) / N);
            end
            if (output_we) begin
                we_cnt++;
                if (int'(output_addr) < N) got_y[output_addr] = int'(y);
                if (output_addr == 0) first_we_rel = rel;
            end
            if (e_we && output_we) begin
                node = rel - (NC + 3);
                check("output_addr", output_addr, node);
                check("y", y, exp_y[node]);
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
        end
    end

    task automatic set_edge(int e, int s, int d);
        coo_src[e*NW +: NW] = NW'(s);
        coo_dst[e*NW +: NW] = NW'(d);
    endtask

    task automatic set_ring();
        for (int e = 0; e < E; e++) set_edge(e, e, (e + 1) % N);
    endtask

    task automatic data_t1();
        for (int n = 0; n < N; n++) for (int k = 0; k < EL; k++) feat[n][k] = 1;
        for (int c = 0; c < C; c++) for (int k = 0; k < EL; k++) wgt[c][k] = c + 1;
    endtask

    task automatic data_rand(int lo);
        for (int n = 0; n < N; n++) for (int k = 0; k < EL; k++) feat[n][k] = $urandom_range(lo, 31);
        for (int c = 0; c < C; c++) for (int k = 0; k < EL; k++) wgt[c][k] = $urandom_range(0, 31);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!active) return;
        end
        checks++;
        errors++;
        $display("FAIL pass_timeout: still busy after 300 cycles, required idle");
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass();
        pulse_start();
        wait_idle();
    endtask

    task automatic wait_rel(int r);
        for (int i = 0; i < 100; i++) begin
            if (active && cyc - e0 + 1 == r) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_rel: cycle %0d never reached", r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, d0;
        #12;
        check("reset_we", output_we, 0);
        check("reset_busy", busy, 0);
        check("reset_addr", output_addr, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: ring, unit features, weight row c = c+1
        set_ring();
        data_t1();
        run_pass();
        check("t1_model_xw02", exp_xw[0][2], 288);
        check("t1_model_xw10", exp_xw[1][0], 96);
        for (int n = 0; n < N; n++) check("t1_y", got_y[n], 2);
        check("t1_first_we_cycle", first_we_rel, 21);
        check("t1_done_cycle", done_rel, 27);

        // 2: duplicate edge plus invalid indices
        set_edge(0, 0, 1); set_edge(1, 0, 1); set_edge(2, 7, 7);
        set_edge(3, 7, 0); set_edge(4, 3, 7); set_edge(5, 7, 7);
        data_rand(1);
        we0 = we_cnt;
        run_pass();
        check("t2_writes", we_cnt - we0, N);
`ifndef GCN_SELF_LOOP_EN
        for (int n = 2; n < N; n++) check("t2_isolated_y", got_y[n], 0);
`endif

        // 3: tie between classes 0 and 1
        set_ring();
        data_rand(1);
        for (int k = 0; k < EL; k++) begin
            wgt[0][k] = 20; wgt[1][k] = 20; wgt[2][k] = 3;
        end
        run_pass();
        for (int n = 0; n < N; n++) check("t3_tie_y", got_y[n], 0);

        // 4: start re-pulsed during FETCH is ignored
        data_rand(0);
        we0 = we_cnt; d0 = done_cnt;
        pulse_start();
        wait_rel(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("t4_writes", we_cnt - we0, N);
        check("t4_dones", done_cnt - d0, 1);

        // 5: async reset in the third OUT cycle, then a clean pass
        set_ring();
        data_t1();
        d0 = done_cnt;
        pulse_start();
        wait_rel(NC + 5);
        check("t5_we_before", output_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_we", output_we, 0);
        check("t5_async_y", y, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_done", done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        for (int n = 0; n < N; n++) got_y[n] = -1;
        run_pass();
        for (int n = 0; n < N; n++) check("t5_rerun_y", got_y[n], 2);
        check("t5_rerun_dones", done_cnt - d0, 1);

        // 6: no valid edges, node n features = n
        for (int e = 0; e < E; e++) set_edge(e, 7, 7);
        data_t1();
        for (int n = 0; n < N; n++) for (int k = 0; k < EL; k++) feat[n][k] = n;
        run_pass();
`ifdef GCN_SELF_LOOP_EN
        for (int n = 0; n < N; n++) check("t6_self_y", got_y[n], (n >= 1) ? 2 : 0);
`else
        for (int n = 0; n < N; n++) check("t6_noself_y", got_y[n], 0);
`endif

        // Random graphs and data
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < E; e++) set_edge(e, $urandom_range(0, 7), $urandom_range(0, 7));
            data_rand(0);
            we0 = we_cnt; d0 = done_cnt;
            run_pass();
            check("rand_writes", we_cnt - we0, N);
            check("rand_dones", done_cnt - d0, 1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
